seq_detector_param: RTL and testbench

- Parametrised Moore serial pattern detector. Generalises the fixed 4-bit "1001" detector.
- Pattern value and length are set by parameters. Adds a per-sample enable, a runtime overlap/non-overlap mode, a saturating match counter and a synchronous counter clear.
- Sits after a serial bit source (sampled pin or shift output).
- z feeds control logic; status and match_count feed debug/LEDs.

---
 rtl/seq_detector_param.sv | 131 +++++++++++++
 tb/tb_seq_detector_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Moore serial pattern detector with saturating match counter.
// Optional idle timeout is built only when SEQDET_IDLE_TIMEOUT_EN is defined.
module seq_detector_param #(
    parameter int                 PAT_W    = 4,
    parameter logic [PAT_W-1:0]   PATTERN  = 4'b1001,
    parameter int                 CNT_W    = 8,
    parameter int                 IDLE_MAX = 16,
    localparam int                SW       = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clear,
    output logic             z,
    output logic [SW-1:0]    status,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [SW-1:0]    K_FULL  = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (PAT_W < 1 || PAT_W > 16 || CNT_W < 1 || CNT_W > 16 || IDLE_MAX < 1) begin : g_param_err
        $error("seq_detector_param: illegal parameter value");
    end

    // Longest prefix of PATTERN that is a suffix of (first k pattern bits, then b).
    function automatic logic [SW-1:0] f_next(input int k, input logic b);
        logic [16:0] t;
        int          len;
        int          best;
        logic        ok;
        t    = '0;
        for (int j = 0; j < PAT_W; j++)
            if (j < k)
                t[j] = PATTERN[PAT_W-1-j];
        t[k] = b;
        len  = k + 1;
        best = 0;
        for (int m = 1; m <= PAT_W; m++) begin
            if (m <= len) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_W; i++)
                    if (i < m && PATTERN[PAT_W-1-i] != t[len-m+i])
                        ok = 1'b0;
                if (ok)
                    best = m;
            end
        end
        return best[SW-1:0];
    endfunction

    logic [SW-1:0] w_tbl0 [PAT_W+1];
    logic [SW-1:0] w_tbl1 [PAT_W+1];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_tbl
        assign w_tbl0[k] = f_next(k, 1'b0);
        assign w_tbl1[k] = f_next(k, 1'b1);
    end

    logic [SW-1:0]    r_state;
    logic             r_z;
    logic [CNT_W-1:0] r_cnt;
    logic [SW-1:0]    w_next;
    logic [SW-1:0]    w_idx;
    logic             w_oor;
    logic             w_hit;

    assign w_oor = ({1'b0, r_state} > {1'b0, K_FULL});
    // Non-overlap mode restarts from the empty prefix after a full match.
    assign w_idx = (r_state == K_FULL && !overlap) ? '0 : r_state;

`ifdef SEQDET_IDLE_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_MAX + 1);
    logic [IW-1:0] r_idle;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            r_idle <= '0;
        else if (en)
            r_idle <= '0;
        else if (r_idle != IW'(IDLE_MAX))
            r_idle <= r_idle + 1'b1;
    end

    always_comb begin
        w_next = r_state;
        if (w_oor)
            w_next = '0;
        else if (en)
            w_next = x ? w_tbl1[w_idx] : w_tbl0[w_idx];
        else if (r_idle == IW'(IDLE_MAX - 1))
            w_next = '0;
    end
`else
    always_comb begin
        w_next = r_state;
        if (w_oor)
            w_next = '0;
        else if (en)
            w_next = x ? w_tbl1[w_idx] : w_tbl0[w_idx];
    end
`endif

    assign w_hit = !w_oor && en && (w_next == K_FULL);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_z     <= (w_next == K_FULL);
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (w_hit && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    assign z           = r_z;
    assign status      = r_state;
    assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for seq_detector_param.
// Three instances cover the default build, CNT_W=2 saturation and a 3-bit all-ones pattern.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset_n, en, x, overlap, clear;

    logic       za;
    logic [2:0] sta;
    logic [7:0] cnta;
    logic       zb;
    logic [2:0] stb;
    logic [1:0] cntb;
    logic       zc;
    logic [1:0] stc;
    logic [7:0] cntc;

    seq_detector_param #(.IDLE_MAX(2)) u_a (
        .clk(clk), .Reset_n(Reset_n), .en(en), .x(x), .overlap(overlap),
        .clear(clear), .z(za), .status(sta), .match_count(cnta)
    );

    seq_detector_param #(.CNT_W(2)) u_b (
        .clk(clk), .Reset_n(Reset_n), .en(en), .x(x), .overlap(overlap),
        .clear(clear), .z(zb), .status(stb), .match_count(cntb)
    );

    seq_detector_param #(.PAT_W(3), .PATTERN(3'b111)) u_c (
        .clk(clk), .Reset_n(Reset_n), .en(en), .x(x), .overlap(overlap),
        .clear(clear), .z(zc), .status(stc), .match_count(cntc)
    );

    typedef struct {
        int    id;
        int    st;
        int    zz;
        int    cn;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        logic [31:0] o_st, o_z, o_cn;
        case (e.id)
            0: begin o_st = 32'(sta); o_z = 32'(za); o_cn = 32'(cnta); end
            1: begin o_st = 32'(stb); o_z = 32'(zb); o_cn = 32'(cntb); end
            default: begin o_st = 32'(stc); o_z = 32'(zc); o_cn = 32'(cntc); end
        endcase
        chk({e.tag, ".status"}, o_st, 32'(e.st));
        chk({e.tag, ".z"}, o_z, 32'(e.zz));
        chk({e.tag, ".count"}, o_cn, 32'(e.cn));
    endtask

    task automatic step(input int id, input logic e, input logic b, input logic cl,
                        input int st, input int zz, input int cn, input string tag);
        exp_t it;
        en    = e;
        x     = b;
        clear = cl;
        sb.push_back('{id, st, zz, cn, tag});
        @(posedge clk);
        #1;
        it = sb.pop_front();
        compare(it);
    endtask

    task automatic do_reset(input string tag);
        en      = 1'b0;
        clear   = 1'b0;
        Reset_n = 1'b0;
        #2;
        compare('{0, 0, 0, 0, tag});
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        en = 1'b0; x = 1'b0; overlap = 1'b1; clear = 1'b0; Reset_n = 1'b0;
        #1;

        // 1: overlapping 1001 stream
        do_reset("rst1");
        overlap = 1'b1;
        step(0, 1, 1, 0, 1, 0, 0, "t1b1");
        step(0, 1, 0, 0, 2, 0, 0, "t1b2");
        step(0, 1, 0, 0, 3, 0, 0, "t1b3");
        step(0, 1, 1, 0, 4, 1, 1, "t1b4");
        step(0, 1, 0, 0, 2, 0, 1, "t1b5");
        step(0, 1, 0, 0, 3, 0, 1, "t1b6");
        step(0, 1, 1, 0, 4, 1, 2, "t1b7");

        // 2: same stream, non-overlapping
        do_reset("rst2");
        overlap = 1'b0;
        step(0, 1, 1, 0, 1, 0, 0, "t2b1");
        step(0, 1, 0, 0, 2, 0, 0, "t2b2");
        step(0, 1, 0, 0, 3, 0, 0, "t2b3");
        step(0, 1, 1, 0, 4, 1, 1, "t2b4");
        step(0, 1, 0, 0, 0, 0, 1, "t2b5");
        step(0, 1, 0, 0, 0, 0, 1, "t2b6");
        step(0, 1, 1, 0, 1, 0, 1, "t2b7");

        // 3: enable gap with toggling x
        do_reset("rst3");
        overlap = 1'b1;
        step(0, 1, 1, 0, 1, 0, 0, "t3b1");
        step(0, 1, 0, 0, 2, 0, 0, "t3b2");
`ifdef SEQDET_IDLE_TIMEOUT_EN
        step(0, 0, 1, 0, 2, 0, 0, "t3gap1");
        step(0, 0, 0, 0, 0, 0, 0, "t3gap2");
        step(0, 0, 1, 0, 0, 0, 0, "t3gap3");
        step(0, 1, 0, 0, 0, 0, 0, "t3b3");
        step(0, 1, 1, 0, 1, 0, 0, "t3b4");
`else
        step(0, 0, 1, 0, 2, 0, 0, "t3gap1");
        step(0, 0, 0, 0, 2, 0, 0, "t3gap2");
        step(0, 0, 1, 0, 2, 0, 0, "t3gap3");
        step(0, 1, 0, 0, 3, 0, 0, "t3b3");
        step(0, 1, 1, 0, 4, 1, 1, "t3b4");
`endif

        // 4: asynchronous reset in the middle of a pattern
        do_reset("rst4");
        overlap = 1'b1;
        step(0, 1, 1, 0, 1, 0, 0, "t4a1");
        step(0, 1, 0, 0, 2, 0, 0, "t4a2");
        step(0, 1, 0, 0, 3, 0, 0, "t4a3");
        step(0, 1, 1, 0, 4, 1, 1, "t4a4");
        step(0, 1, 0, 0, 2, 0, 1, "t4a5");
        step(0, 1, 0, 0, 3, 0, 1, "t4a6");
        en      = 1'b0;
        Reset_n = 1'b0;
        #2;
        compare('{0, 0, 0, 0, "t4async"});
        Reset_n = 1'b1;
        step(0, 1, 1, 0, 1, 0, 0, "t4b1");
        step(0, 1, 0, 0, 2, 0, 0, "t4b2");
        step(0, 1, 0, 0, 3, 0, 0, "t4b3");
        step(0, 1, 1, 0, 4, 1, 1, "t4b4");

        // 5: CNT_W=2 saturation, then clear beating a match
        do_reset("rst5");
        overlap = 1'b1;
        step(1, 1, 1, 0, 1, 0, 0, "t5a1");
        step(1, 1, 0, 0, 2, 0, 0, "t5a2");
        step(1, 1, 0, 0, 3, 0, 0, "t5a3");
        step(1, 1, 1, 0, 4, 1, 1, "t5m1");
        for (int m = 2; m <= 5; m++) begin
            step(1, 1, 0, 0, 2, 0, (m - 1 > 3) ? 3 : m - 1, $sformatf("t5g%0d", m));
            step(1, 1, 0, 0, 3, 0, (m - 1 > 3) ? 3 : m - 1, $sformatf("t5h%0d", m));
            step(1, 1, 1, 0, 4, 1, (m > 3) ? 3 : m, $sformatf("t5m%0d", m));
        end
        step(1, 1, 0, 0, 2, 0, 3, "t5g6");
        step(1, 1, 0, 0, 3, 0, 3, "t5h6");
        step(1, 1, 1, 1, 4, 1, 0, "t5clr");

        // 6: PATTERN=111, overlap then non-overlap
        do_reset("rst6");
        overlap = 1'b1;
        step(2, 1, 1, 0, 1, 0, 0, "t6o1");
        step(2, 1, 1, 0, 2, 0, 0, "t6o2");
        step(2, 1, 1, 0, 3, 1, 1, "t6o3");
        step(2, 1, 1, 0, 3, 1, 2, "t6o4");
        step(2, 1, 1, 0, 3, 1, 3, "t6o5");
        do_reset("rst7");
        overlap = 1'b0;
        step(2, 1, 1, 0, 1, 0, 0, "t6n1");
        step(2, 1, 1, 0, 2, 0, 0, "t6n2");
        step(2, 1, 1, 0, 3, 1, 1, "t6n3");
        step(2, 1, 1, 0, 1, 0, 1, "t6n4");
        step(2, 1, 1, 0, 2, 0, 1, "t6n5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
